pipelined_magnitude_comparator: RTL and testbench

- Parametrised, pipelined magnitude comparator for two WIDTH-bit operands, evaluated MSB-first one SLICE-bit slice per stage.
- Produces a registered one-hot greater/equal/less result with valid/ready flow control.
- Supports per-transaction signed or unsigned comparison.
- Replaces the fixed 4-bit single-register comparator wherever operands are wider or results must be streamed back-to-back.

---
 rtl/pipelined_magnitude_comparator.sv | 140 ++++++++++++++
 tb/tb_pipelined_magnitude_comparator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_magnitude_comparator.sv
// Pipelined MSB-first magnitude comparator with valid/ready flow control.
// Optional two's-complement mode is built only when PMC_SIGNED_EN is defined.
//
// Parameters:
//   WIDTH  operand width; must be a multiple of SLICE
//   SLICE  bits compared per stage; STAGES = WIDTH / SLICE
// Ports:
//   clk, rst           rising-edge clock, async active-high reset
//   in_valid/in_ready  input handshake for A, B, is_signed
//   A, B               WIDTH-bit operands
//   is_signed          1 = signed compare (ignored without PMC_SIGNED_EN)
//   out_valid/out_ready output handshake
//   Y2, Y1, Y0         one-hot A>B, A==B, A<B (registered)
module pipelined_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Y2,
  output logic             Y1,
  output logic             Y0
);

  localparam int STAGES = WIDTH / SLICE;

  // {gt, eq, lt} encodings
  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  logic                          stall;
  logic [WIDTH-1:0]              msb_flip;

  logic [STAGES-1:0][WIDTH-1:0]  ain;
  logic [STAGES-1:0][WIDTH-1:0]  bin;
  logic [STAGES-1:0][2:0]        rin;

  logic [STAGES-1:0]             vld_d;
  logic [STAGES-1:0]             vld_q;
  logic [STAGES-1:0][2:0]        res_d;
  logic [STAGES-1:0][2:0]        res_q;
  logic [STAGES-1:0][WIDTH-1:0]  a_d;
  logic [STAGES-1:0][WIDTH-1:0]  a_q;
  logic [STAGES-1:0][WIDTH-1:0]  b_d;
  logic [STAGES-1:0][WIDTH-1:0]  b_q;

  // Global stall: the whole pipe freezes when the head is blocked.
  assign stall    = vld_q[STAGES-1] && !out_ready;
  assign in_ready = !stall;

  // Signed compare reduces to unsigned once both MSBs are inverted.
`ifdef PMC_SIGNED_EN
  always_comb begin
    msb_flip          = '0;
    msb_flip[WIDTH-1] = is_signed;
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign msb_flip         = '0;
`endif

  // Stage inputs: stage 0 from the ports, others from the previous stage.
  always_comb begin
    ain      = '0;
    bin      = '0;
    rin      = '0;
    vld_d    = '0;
    ain[0]   = A ^ msb_flip;
    bin[0]   = B ^ msb_flip;
    rin[0]   = RES_EQ;
    vld_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      ain[k]   = a_q[k-1];
      bin[k]   = b_q[k-1];
      rin[k]   = res_q[k-1];
      vld_d[k] = vld_q[k-1];
    end
  end

  // Each stage resolves its top slice; operands shift up so the
  // next slice always sits in the top SLICE bits.
  always_comb begin
    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    sa    = '0;
    sb    = '0;
    res_d = '0;
    a_d   = '0;
    b_d   = '0;
    for (int k = 0; k < STAGES; k++) begin
      sa     = ain[k][WIDTH-1 -: SLICE];
      sb     = bin[k][WIDTH-1 -: SLICE];
      a_d[k] = ain[k] << SLICE;
      b_d[k] = bin[k] << SLICE;
      // Bubbles carry 000 so the outputs read zero when not valid.
      if (vld_d[k]) begin
        if (!rin[k][1]) begin
          res_d[k] = rin[k];
        end else begin
          unique case (1'b1)
            (sa > sb):  res_d[k] = RES_GT;
            (sa == sb): res_d[k] = RES_EQ;
            (sa < sb):  res_d[k] = RES_LT;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      res_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (!stall) begin
      vld_q <= vld_d;
      res_q <= res_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  // Operands leaving the last stage have no further use.
  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1]};

  assign out_valid    = vld_q[STAGES-1];
  assign {Y2, Y1, Y0} = res_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_magnitude_comparator.sv
// Self-checking bench for pipelined_magnitude_comparator.
// Directed latency/stall/reset steps followed by a randomized stream.
module tb_pipelined_magnitude_comparator;

  localparam int WIDTH = 16;
  localparam int LAT   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             Y2, Y1, Y0;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] exp_q[$];
  logic       last_ov;
  logic [2:0] last_y;

  pipelined_magnitude_comparator dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .is_signed(is_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Y2       (Y2),
    .Y1       (Y1),
    .Y0       (Y0)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_cmp(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             s
  );
    int ia, ib;
    logic use_s;
`ifdef PMC_SIGNED_EN
    use_s = s;
`else
    use_s = 1'b0;
`endif
    if (use_s) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    if (ia > ib)       return 3'b100;
    else if (ia == ib) return 3'b010;
    else               return 3'b001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive at negedge, check, then let the posedge pass.
  task automatic cyc(input logic v, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] b, input logic s,
                     input logic ordy);
    logic [2:0] y;
    @(negedge clk);
    in_valid  = v;
    A         = a;
    B         = b;
    is_signed = s;
    out_ready = ordy;
    #1;
    y       = {Y2, Y1, Y0};
    last_ov = out_valid;
    last_y  = y;
    chk("in_ready", 32'(in_ready), 32'(!(out_valid && !ordy)));
    if (out_valid)
      chk("one_hot", 32'($countones(y)), 32'd1);
    if (out_valid && ordy) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        chk("result", 32'(y), 32'(exp_q.pop_front()));
    end
    if (v && in_ready)
      exp_q.push_back(ref_cmp(a, b, s));
    @(posedge clk);
  endtask

  task automatic bub(input logic ordy);
    cyc(1'b0, '0, '0, 1'b0, ordy);
  endtask

  initial begin
    logic [2:0]       held;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH-1:0] spec_v[4];
    spec_v[0] = 16'h0000;
    spec_v[1] = 16'hFFFF;
    spec_v[2] = 16'h8000;
    spec_v[3] = 16'h7FFF;

    rst = 1'b1;
    in_valid = 1'b0; A = '0; B = '0; is_signed = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'({Y2, Y1, Y0}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    // Unsigned equality and its latency
    cyc(1'b1, 16'h1234, 16'h1234, 1'b0, 1'b1);
    for (int i = 0; i < LAT; i++) begin
      bub(1'b1);
      chk("lat_eq_ov", 32'(last_ov), 32'(i == LAT - 1));
    end
    chk("eq_y", 32'(last_y), 32'b010);

    // LSB-only difference
    cyc(1'b1, 16'h0001, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < LAT; i++) begin
      bub(1'b1);
      chk("lat_lsb_ov", 32'(last_ov), 32'(i == LAT - 1));
    end
    chk("lsb_y", 32'(last_y), 32'b100);

    // Signed vs unsigned on the sign boundary
    cyc(1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
    cyc(1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b1);
    for (int i = 0; i < LAT; i++) bub(1'b1);

    // Back-to-back stream: results on consecutive cycles
    cyc(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b1);
    cyc(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    cyc(1'b1, 16'h9000, 16'h1000, 1'b0, 1'b1);
    cyc(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1);
    chk("stream_early", 32'(last_ov), 32'd0);
    for (int i = 0; i < LAT; i++) begin
      bub(1'b1);
      chk("stream_ov", 32'(last_ov), 32'd1);
    end
    bub(1'b1);
    chk("stream_end", 32'(last_ov), 32'd0);

    // Backpressure: hold for 3 cycles, offered input must not enter
    cyc(1'b1, 16'h0100, 16'h0200, 1'b0, 1'b1);
    cyc(1'b1, 16'h0300, 16'h0300, 1'b0, 1'b1);
    cyc(1'b1, 16'h0500, 16'h0400, 1'b0, 1'b1);
    bub(1'b1);
    cyc(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    held = last_y;
    chk("bp_ov0", 32'(last_ov), 32'd1);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
      chk("bp_ov", 32'(last_ov), 32'd1);
      chk("bp_hold", 32'(last_y), 32'(held));
    end
    for (int i = 0; i < 3; i++) begin
      bub(1'b1);
      chk("bp_drain_ov", 32'(last_ov), 32'd1);
    end
    bub(1'b1);
    chk("bp_gone", 32'(last_ov), 32'd0);

    // Reset with three transactions in flight
    cyc(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1);
    cyc(1'b1, 16'h0003, 16'h0003, 1'b0, 1'b1);
    cyc(1'b1, 16'h0005, 16'h0004, 1'b0, 1'b1);
    bub(1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_y", 32'({Y2, Y1, Y0}), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      bub(1'b1);
      chk("no_stale", 32'(last_ov), 32'd0);
    end
    cyc(1'b1, 16'hC000, 16'hC001, 1'b0, 1'b1);
    for (int i = 0; i < LAT; i++) begin
      bub(1'b1);
      chk("post_rst_lat", 32'(last_ov), 32'(i == LAT - 1));
    end

    // Randomized stream with random backpressure
    for (int i = 0; i < 400; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) ra = spec_v[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) rb = spec_v[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
      if ($urandom_range(0, 5) == 0) rb = ra;
      cyc(1'($urandom_range(0, 4) != 0), ra, rb, 1'($urandom),
          1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < LAT + 2; i++) bub(1'b1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
